// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and opcode width.
// Used by alu_seq, the ALU itself and anything that drives commands.
// No logic here, only types and constants.
package alu_pkg;

    localparam int ALU_OP_W = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_seq_if.sv
// Command and response channels between a requester and alu_seq.
// Pure wiring, no latency.
// Both channels are valid/ready; the requester side is the master.
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [DATA_WIDTH-1:0] cmd_a_i;
    logic [DATA_WIDTH-1:0] cmd_b_i;
    alu_op_e               cmd_op_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_data_o;

    // Requester side: issues commands, consumes responses.
    modport master (
        output cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i, rsp_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o
    );

    // alu_seq side: accepts commands, produces responses.
    modport slave (
        input  cmd_valid_i, cmd_a_i, cmd_b_i, cmd_op_i, rsp_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o
    );

endinterface

// File: rtl/alu.sv
// Registered two-operand ALU (ADD/SUB/AND/OR), sibling of alu_seq.
// Latency: one clock from operands to result_o.
// No backpressure: computes every cycle from whatever operands are presented.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  alu_op_e               op_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    logic [DATA_WIDTH-1:0] result_d;
    logic [DATA_WIDTH-1:0] result_q;

    // Combinational operation select; wrap-around is intentionally silent.
    always_comb begin
        result_d = '0;
        unique case (op_i)
            OP_ADD: result_d = a_i + b_i;
            OP_SUB: result_d = a_i - b_i;
            OP_AND: result_d = a_i & b_i;
            OP_OR:  result_d = a_i | b_i;
            default: result_d = '0;
        endcase
    end

    // Result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/alu_seq.sv
// Sequencer for an external registered ALU: one command in flight, result returned on rsp channel.
// Latency: rsp_valid_o rises LATENCY+1 clocks after the accept edge.
// Backpressure: cmd_ready_o only in IDLE; response held until rsp_ready_i. Option: ALU_SEQ_STATS_EN adds stat_count_o.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_seq_if.slave              bus,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    output alu_op_e               alu_op_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
`ifdef ALU_SEQ_STATS_EN
    output logic [31:0]           stat_count_o,
`endif
    output logic                  busy_o
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    alu_op_e               op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rsp_hs;

    assign rsp_hs = (state_q == S_RESP) && bus.rsp_ready_i;

    // Next-state and datapath-load decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    a_d     = bus.cmd_a_i;
                    b_d     = bus.cmd_b_i;
                    op_d    = bus.cmd_op_i;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    data_d  = alu_result_i;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and operand/result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    // Ready is masked by reset so every output reads 0 while rst_n is low.
    assign bus.cmd_ready_o = (state_q == S_IDLE) && rst_n;
    assign bus.rsp_valid_o = (state_q == S_RESP);
    assign bus.rsp_data_o  = data_q;
    assign busy_o          = (state_q != S_IDLE);
    assign alu_a_o         = a_q;
    assign alu_b_o         = b_q;
    assign alu_op_o        = op_q;

`ifdef ALU_SEQ_STATS_EN
    logic [31:0] stat_q;

    // Completed-response counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (rsp_hs) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stat_count_o = stat_q;
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench: alu_seq wired to the registered ALU, LATENCY=1, DATA_WIDTH=32.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    alu_op_e       alu_op;
    logic          busy;
`ifdef ALU_SEQ_STATS_EN
    logic [31:0]   stat_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.DATA_WIDTH(DW)) bus_if ();

    alu_seq #(
        .DATA_WIDTH (DW),
        .LATENCY    (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_result),
`ifdef ALU_SEQ_STATS_EN
        .stat_count_o (stat_count),
`endif
        .busy_o       (busy)
    );

    alu #(.DATA_WIDTH(DW)) u_alu (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alu_a"},     alu_a, 32'h0);
        check({tag, ".alu_b"},     alu_b, 32'h0);
        check({tag, ".alu_op"},    32'(alu_op), 32'h0);
        check({tag, ".rsp_valid"}, 32'(bus_if.rsp_valid_o), 32'h0);
        check({tag, ".rsp_data"},  bus_if.rsp_data_o, 32'h0);
        check({tag, ".busy"},      32'(busy), 32'h0);
        check({tag, ".cmd_ready"}, 32'(bus_if.cmd_ready_o), 32'h0);
    endtask

    // Called at a negedge with the DUT idle. Offers a command, checks the
    // accept, the accept+2 response and holds rsp_ready low for 'stall'
    // cycles. If 'noise' is set, cmd_valid stays high with junk operands
    // while busy; the DUT must ignore it. Returns at the negedge after the
    // response handshake.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input alu_op_e op, input logic [31:0] exp,
                          input int stall, input bit noise);
        check({tag, ".ready_before"}, 32'(bus_if.cmd_ready_o), 32'h1);
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_a_i     = a;
        bus_if.cmd_b_i     = b;
        bus_if.cmd_op_i    = op;
        bus_if.rsp_ready_i = 1'b0;
        @(negedge clk);                       // accept edge passed
        bus_if.cmd_valid_i = noise;
        bus_if.cmd_a_i     = 32'hDEADBEEF;
        bus_if.cmd_b_i     = 32'hCAFEF00D;
        bus_if.cmd_op_i    = OP_OR;
        check({tag, ".alu_a"},     alu_a, a);
        check({tag, ".alu_b"},     alu_b, b);
        check({tag, ".alu_op"},    32'(alu_op), 32'(op));
        check({tag, ".busy"},      32'(busy), 32'h1);
        check({tag, ".cmd_ready"}, 32'(bus_if.cmd_ready_o), 32'h0);
        check({tag, ".valid_acc1"}, 32'(bus_if.rsp_valid_o), 32'h0);
        @(negedge clk);                       // accept + 1
        check({tag, ".valid_acc1b"}, 32'(bus_if.rsp_valid_o), 32'h0);
        @(negedge clk);                       // accept + 2
        check({tag, ".valid_acc2"}, 32'(bus_if.rsp_valid_o), 32'h1);
        check({tag, ".data"},       bus_if.rsp_data_o, exp);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ".stall_valid"}, 32'(bus_if.rsp_valid_o), 32'h1);
            check({tag, ".stall_data"},  bus_if.rsp_data_o, exp);
            check({tag, ".stall_ready"}, 32'(bus_if.cmd_ready_o), 32'h0);
            check({tag, ".stall_alu_a"}, alu_a, a);
        end
        bus_if.cmd_valid_i = 1'b0;
        bus_if.rsp_ready_i = 1'b1;
        @(negedge clk);                       // handshake edge passed
        bus_if.rsp_ready_i = 1'b0;
        check({tag, ".valid_after"}, 32'(bus_if.rsp_valid_o), 32'h0);
        check({tag, ".ready_after"}, 32'(bus_if.cmd_ready_o), 32'h1);
        check({tag, ".busy_after"},  32'(busy), 32'h0);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus_if.cmd_valid_i = 1'b0;
        bus_if.cmd_a_i     = '0;
        bus_if.cmd_b_i     = '0;
        bus_if.cmd_op_i    = OP_ADD;
        bus_if.rsp_ready_i = 1'b0;

        #2;
        check_all_zero("reset");
`ifdef ALU_SEQ_STATS_EN
        check("reset.stat", stat_count, 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release.cmd_ready", 32'(bus_if.cmd_ready_o), 32'h1);
        @(negedge clk);

        run_op("add", 32'd5, 32'd3, OP_ADD, 32'h00000008, 0, 1'b0);
        run_op("sub", 32'd3, 32'd5, OP_SUB, 32'hFFFFFFFE, 0, 1'b0);
        run_op("and", 32'hF0F0F0F0, 32'hFF00FF00, OP_AND, 32'hF000F000, 4, 1'b1);
`ifdef ALU_SEQ_STATS_EN
        check("stat.three", stat_count, 32'd3);
`endif
        // Issued immediately: the DUT must be ready the cycle after the AND handshake.
        run_op("or", 32'h1, 32'h2, OP_OR, 32'h00000003, 0, 1'b0);
`ifdef ALU_SEQ_STATS_EN
        check("stat.four", stat_count, 32'd4);
`endif
        run_op("add_wrap", 32'hFFFFFFFF, 32'h2, OP_ADD, 32'h00000001, 0, 1'b0);

        // Reset in the middle of WAIT.
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_a_i     = 32'h10;
        bus_if.cmd_b_i     = 32'h20;
        bus_if.cmd_op_i    = OP_ADD;
        @(negedge clk);
        bus_if.cmd_valid_i = 1'b0;
        check("rst_wait.busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait");
`ifdef ALU_SEQ_STATS_EN
        check("rst_wait.stat", stat_count, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel.cmd_ready", 32'(bus_if.cmd_ready_o), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_rel.no_rsp", 32'(bus_if.rsp_valid_o), 32'h0);
            check("rst_rel.idle", 32'(busy), 32'h0);
        end

        run_op("post_rst", 32'hA5A5A5A5, 32'h0F0F0F0F, OP_OR, 32'hAFAFAFAF, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter LATENCY, default 1: ALU result latency in clocks; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports cmd_valid_i (input, 1) and cmd_ready_o (output, 1): command handshake.
REQ-006 SHALL have ports cmd_a_i and cmd_b_i (input, DATA_WIDTH each) and cmd_op_i (input, 2): command operands and opcode.
REQ-007 SHALL have ports alu_a_o and alu_b_o (output, DATA_WIDTH each) and alu_op_o (output, 2): the ALU operands and opcode it drives.
REQ-008 SHALL have port alu_result_i, input, DATA_WIDTH: registered result returned by the ALU.
REQ-009 SHALL have ports rsp_valid_o (output, 1), rsp_ready_i (input, 1) and rsp_data_o (output, DATA_WIDTH): response handshake and result.
REQ-010 SHALL have port busy_o, output, 1: high in any state except IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT and RESP; opcodes are ADD=00, SUB=01, AND=10, OR=11.
REQ-012 SHALL assert cmd_ready_o only in IDLE, so at most one command is in flight.
REQ-013 On an accept edge (IDLE with cmd_valid_i=1), SHALL:
- register cmd_a_i, cmd_b_i and cmd_op_i onto alu_a_o, alu_b_o and alu_op_o;
- load the wait counter with LATENCY;
- go to WAIT.
REQ-014 SHALL hold alu_a_o, alu_b_o and alu_op_o stable from one accept until the next accept.
REQ-015 In WAIT, SHALL decrement the counter each edge while it is nonzero.
REQ-016 In WAIT with counter=0, SHALL capture alu_result_i into rsp_data_o and go to RESP; rsp_valid_o therefore rises LATENCY+1 cycles after the accept edge.
REQ-017 In RESP, SHALL hold rsp_valid_o=1 and rsp_data_o stable until rsp_ready_i=1.
REQ-018 On the RESP handshake edge, SHALL go to IDLE with rsp_valid_o=0.
REQ-019 In the cycle after REQ-018, SHALL assert cmd_ready_o; there is no same-cycle response-to-command bypass.
REQ-020 SHALL ignore cmd_valid_i outside IDLE, and cmd_* values while cmd_valid_i=0.
REQ-021 SHALL pass results through unchanged at DATA_WIDTH bits; ALU wrap-around is not detected or flagged.

Reset
REQ-022 While rst_n=0, SHALL immediately force:
- state = IDLE and counter = 0;
- alu_a_o, alu_b_o and alu_op_o = 0;
- rsp_data_o = 0, rsp_valid_o = 0, busy_o = 0.
REQ-023 SHALL drive cmd_ready_o=1 in the first cycle after reset release.
REQ-024 A reset during WAIT or RESP SHALL drop the in-flight operation; no response is emitted for it.

Configuration
REQ-025 With macro ALU_SEQ_STATS_EN defined, SHALL add output stat_count_o (32 bits, reset 0) that increments on each RESP handshake and wraps from 0xFFFFFFFF to 0.
REQ-026 Without ALU_SEQ_STATS_EN, the port and the counter SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Shared package alu_pkg SHALL hold:
- enum alu_op_e (ADD, SUB, AND, OR, 2 bits);
- constant ALU_OP_W = 2.
REQ-028 The FSM state enum SHALL be local to alu_seq.
REQ-029 SHALL contain no sub-module; alu_seq and the ALU are siblings wired at the level above.

Verification
REQ-030 The bench SHALL instantiate alu_seq with the team ALU (LATENCY=1, DATA_WIDTH=32) and cover these directed scenarios:
- ADD a=5, b=3 -> rsp_valid_o at accept+2, rsp_data_o=0x00000008.
- SUB a=3, b=5 -> rsp_data_o=0xFFFFFFFE.
- AND a=0xF0F0F0F0, b=0xFF00FF00, rsp_ready_i low for 4 cycles -> rsp_data_o=0xF000F000 stable throughout; cmd_ready_o=0 throughout.
- OR a=0x1, b=0x2 issued back-to-back after the AND response -> cmd_ready_o high the cycle after the handshake; rsp_data_o=0x00000003.
- rst_n pulsed low during WAIT -> all outputs 0 at once; no response afterwards; cmd_ready_o=1 after release.
- With ALU_SEQ_STATS_EN defined: 3 completed ops -> stat_count_o=3; a reset returns it to 0.
